// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver with a byte FIFO, DATA/STATUS registers and a level interrupt.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module uart_rx_mmio #(
   parameter int CLK_DIV = 16,
   parameter int FIFO_AW = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   input  logic        rd_en,
   input  logic        addr,
   output logic [31:0] rdata,
   output logic        rx_irq
);
   localparam int CW    = $clog2(CLK_DIV);
   localparam int PW    = FIFO_AW + 1;
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [CW-1:0] CNT_BIT  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HI
   } state_t;

   logic          rx_meta_q, rx_s_q;
   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bitn_q;
   logic [7:0]    shift_q;
   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic          overrun_q, overrun_d, frame_err_q, frame_err_d, parity_err_q, parity_err_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          rx_irq_q;
   logic          bit_end, push, frame_set, parity_set;
   logic          empty, full, pop, status_rd, push_ok;

   always_comb begin
      bit_end   = (cnt_q == CNT_BIT);
      push      = (state_q == S_STOP) && bit_end && rx_s_q;
      frame_set = (state_q == S_STOP) && bit_end && !rx_s_q;
`ifdef UART_RX_PARITY_EN
      parity_set = (state_q == S_PARITY) && bit_end && ((^shift_q) != rx_s_q);
`else
      parity_set = 1'b0;
`endif
      empty     = (wr_ptr_q == rd_ptr_q);
      full      = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                  (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
      pop       = rd_en && !addr && !empty;
      status_rd = rd_en && addr;
      // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
      push_ok   = push && (!full || pop);
      rd_ptr_d  = rd_ptr_q + PW'(pop);
      wr_ptr_d  = wr_ptr_q + PW'(push_ok);
      overrun_d    = (push && !push_ok) || (overrun_q && !status_rd);
      frame_err_d  = frame_set || (frame_err_q && !status_rd);
      parity_err_d = parity_set || (parity_err_q && !status_rd);
      rdata_d = rdata_q;
      if (rd_en) begin
         if (addr)
            rdata_d = {27'b0, parity_err_q, frame_err_q, overrun_q, full, !empty};
         else if (pop)
            rdata_d = {24'b0, mem_q[rd_ptr_q[FIFO_AW-1:0]]};
         else
            rdata_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bitn_q    <= '0;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         cnt_q     <= cnt_q + 1'b1;
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (!rx_s_q) state_q <= S_START;
            end
            S_START: begin
               if (cnt_q == CNT_HALF) begin
                  cnt_q   <= '0;
                  bitn_q  <= '0;
                  state_q <= rx_s_q ? S_IDLE : S_DATA;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  cnt_q           <= '0;
                  shift_q[bitn_q] <= rx_s_q;
                  bitn_q          <= bitn_q + 1'b1;
                  if (bitn_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= S_PARITY;
`else
                     state_q <= S_STOP;
`endif
                  end
               end
            end
            S_PARITY: begin
               if (bit_end) begin
                  cnt_q   <= '0;
                  state_q <= S_STOP;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  cnt_q   <= '0;
                  state_q <= rx_s_q ? S_IDLE : S_WAIT_HI;
               end
            end
            S_WAIT_HI: begin
               cnt_q <= '0;
               if (rx_s_q) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         overrun_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         rdata_q      <= '0;
         rx_irq_q     <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         overrun_q    <= overrun_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         rdata_q      <= rdata_d;
         rx_irq_q     <= (wr_ptr_d != rd_ptr_d);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= shift_q;
   end

   assign rdata  = rdata_q;
   assign rx_irq = rx_irq_q;
endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed and randomized bench for uart_rx_mmio against a queue-based reference model.
module tb_uart_rx_mmio;
   localparam int CLK_DIV = 16;
   localparam int DEPTH   = 8;
`ifdef UART_RX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx = 1'b1;
   logic        rd_en = 1'b0;
   logic        addr = 1'b0;
   logic [31:0] rdata;
   logic        rx_irq;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] model_q[$];
   bit m_ovr = 0, m_frm = 0, m_par = 0;

   uart_rx_mmio #(.CLK_DIV(CLK_DIV), .FIFO_AW(3)) dut (
      .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .addr(addr),
      .rdata(rdata), .rx_irq(rx_irq)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL timeout: observed no end of test, required end before time limit");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drives one frame; optionally pops DATA on the cycle the stop bit is sampled.
   task automatic send_frame(input logic [7:0] b, input logic par_bit, input logic stop_bit,
                             input bit pop_at_stop, output logic [31:0] popped);
      int   nb;
      logic bv;
      nb = 10 + PAR;
      popped = '0;
      for (int i = 0; i < nb; i++) begin
         if (i == 0)           bv = 1'b0;
         else if (i <= 8)      bv = b[i-1];
         else if (i == nb - 1) bv = stop_bit;
         else                  bv = par_bit;
         rx = bv;
         for (int j = 0; j < CLK_DIV; j++) begin
            @(negedge clk);
            if (pop_at_stop && i == nb - 1 && j == 9) begin
               rd_en = 1'b1;
               addr  = 1'b0;
            end
            if (pop_at_stop && i == nb - 1 && j == 10) begin
               rd_en  = 1'b0;
               popped = rdata;
            end
         end
      end
      rx = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic [31:0] dummy;
      send_frame(b, ^b, 1'b1, 1'b0, dummy);
   endtask

   task automatic read_reg(input logic a, output logic [31:0] d);
      rd_en = 1'b1;
      addr  = a;
      @(negedge clk);
      rd_en = 1'b0;
      d = rdata;
   endtask

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s = {27'b0, m_par, m_frm, m_ovr, model_q.size() == DEPTH, model_q.size() != 0};
      m_par = 0; m_frm = 0; m_ovr = 0;
      return s;
   endfunction

   function automatic logic [31:0] model_data();
      if (model_q.size() == 0) return 32'h0;
      return {24'b0, model_q.pop_front()};
   endfunction

   initial begin
      logic [31:0] d, popped;
      logic [7:0]  b;
      int          op;
      bit          bad_stop, bad_par;

      repeat (3) @(negedge clk);
      check("reset_rdata", rdata, 32'h0);
      check("reset_irq", {31'b0, rx_irq}, 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      read_reg(1'b1, d); check("reset_status", d, 32'h0);

      send_byte(8'h55);
      check("irq_after_55", {31'b0, rx_irq}, 32'h1);
      read_reg(1'b1, d); check("status_55", d, 32'h01);
      read_reg(1'b0, d); check("data_55", d, 32'h55);
      @(negedge clk);
      check("irq_after_pop", {31'b0, rx_irq}, 32'h0);
      read_reg(1'b1, d); check("status_after_55", d, 32'h00);

      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (30) @(negedge clk);
      read_reg(1'b1, d); check("glitch_status", d, 32'h00);
      check("glitch_irq", {31'b0, rx_irq}, 32'h0);

      send_frame(8'hA3, ^8'hA3, 1'b0, 1'b0, popped);
      check("frame_err_irq", {31'b0, rx_irq}, 32'h0);
      read_reg(1'b1, d); check("frame_err_status", d, 32'h08);
      read_reg(1'b1, d); check("frame_err_cleared", d, 32'h00);

      for (int i = 1; i <= 9; i++) send_byte(8'(i));
      read_reg(1'b1, d); check("overrun_status", d, 32'h07);
      for (int i = 1; i <= 8; i++) begin
         read_reg(1'b0, d); check("overrun_data", d, 32'(i));
      end
      read_reg(1'b0, d); check("empty_pop", d, 32'h0);
      read_reg(1'b1, d); check("overrun_drained", d, 32'h00);

      for (int i = 1; i <= 8; i++) send_byte(8'(i));
      send_frame(8'h09, ^8'h09, 1'b1, 1'b1, popped);
      check("pop_at_stop_data", popped, 32'h01);
      read_reg(1'b1, d); check("pop_at_stop_status", d, 32'h03);
      for (int i = 2; i <= 9; i++) begin
         read_reg(1'b0, d); check("pop_at_stop_drain", d, 32'(i));
      end
      read_reg(1'b1, d); check("pop_at_stop_empty", d, 32'h00);

      rx = 1'b0;
      repeat (CLK_DIV) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      send_byte(8'h3C);
      read_reg(1'b1, d); check("midreset_status", d, 32'h01);
      read_reg(1'b0, d); check("midreset_data", d, 32'h3C);
      read_reg(1'b1, d); check("midreset_empty", d, 32'h00);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b0, 1'b1, 1'b0, popped);
      read_reg(1'b1, d); check("parity_status", d, 32'h11);
      read_reg(1'b0, d); check("parity_data", d, 32'h07);
      read_reg(1'b1, d); check("parity_cleared", d, 32'h00);
`endif

      for (int k = 0; k < 40; k++) begin
         op = $urandom_range(0, 3);
         if (op <= 1) begin
            b        = 8'($urandom);
            bad_stop = ($urandom_range(0, 7) == 0);
            bad_par  = (PAR != 0) && ($urandom_range(0, 7) == 0);
            send_frame(b, bad_par ? ~(^b) : (^b), !bad_stop, 1'b0, popped);
            if (bad_par) m_par = 1;
            if (bad_stop) m_frm = 1;
            else if (model_q.size() == DEPTH) m_ovr = 1;
            else model_q.push_back(b);
         end else if (op == 2) begin
            read_reg(1'b0, d); check("rand_data", d, model_data());
         end else begin
            read_reg(1'b1, d); check("rand_status", d, model_status());
         end
      end
      while (model_q.size() != 0) begin
         read_reg(1'b0, d); check("rand_drain", d, model_data());
      end
      read_reg(1'b1, d); check("rand_final_status", d, model_status());
      @(negedge clk);
      check("rand_final_irq", {31'b0, rx_irq}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
